// File: rtl/ps2_seq_pkg.sv
// Shared types and byte constants for the PS/2 scan-code sequencer.
package ps2_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } seq_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = 10;

    localparam logic [7:0] PFX_EXT     = 8'hE0;
    localparam logic [7:0] PFX_BRK     = 8'hF0;
    localparam logic [7:0] PFX_PAUSE   = 8'hE1;
    localparam logic [7:0] BAT_OK      = 8'hAA;
    localparam logic [7:0] ACK         = 8'hFA;
    localparam logic [7:0] RESEND      = 8'hFE;
    localparam logic [7:0] ECHO        = 8'hEE;
    localparam logic [7:0] KBD_ERR_LO  = 8'h00;
    localparam logic [7:0] KBD_ERR_HI  = 8'hFF;
    localparam logic [7:0] FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] FAKE_RSHIFT = 8'h59;

    // Bytes that follow E1 before the Pause sequence is complete.
    localparam int PAUSE_TAIL = 7;

    // Keyboard status/response bytes that never form a key event.
    function automatic logic is_status(input logic [7:0] b);
        return (b == BAT_OK) || (b == ACK) || (b == RESEND) || (b == ECHO) ||
               (b == KBD_ERR_LO) || (b == KBD_ERR_HI);
    endfunction

    // Shift codes the keyboard injects around E0 keys to emulate shift state.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == FAKE_LSHIFT) || (b == FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO. Pointers carry one extra wrap bit;
// full/empty come from comparing that bit alongside the index bits.
// A push while full is accepted only when a pop frees a slot on the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; both may advance on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage; contents are only observed through a valid head entry.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer: turns the receiver byte stream into make/break
// events with an extended flag, handles E0/F0/E1 prefixes, drops status
// bytes, aborts stalled multi-byte sequences and queues events in a FIFO.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeats.
//
// state   | meaning
// S_IDLE  | waiting for the first byte of a sequence
// S_E0    | E0 seen, expecting code or F0
// S_F0    | F0 seen, expecting code of released key
// S_E0F0  | E0 F0 seen, expecting code of released extended key
// S_PAUSE | E1 seen, counting the fixed Pause tail bytes
module ps2_scan_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_ovf,
    input  logic       ovf_clr,
    output logic       seq_busy
);

    localparam int              TMR_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(TIMEOUT_CYC - 1);
    localparam int              PC_W       = $clog2(PAUSE_TAIL + 1);
    localparam logic [PC_W-1:0]  PAUSE_LAST = PC_W'(PAUSE_TAIL - 1);

    seq_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic             seq_busy_q;
    logic             evt_ovf_q, evt_ovf_d;

    logic             dec_push;
    ps2_evt_t         dec_evt;
    logic             suppress;
    logic             push, pop, push_ok;
    logic             fifo_full, fifo_empty;
    logic [EVT_W-1:0] fifo_rdata;
    ps2_evt_t         head;

    // Byte decode, next state and inter-byte timer; error beats data, data beats timeout.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        dec_push = 1'b0;
        dec_evt  = '{ext: 1'b0, brk: 1'b0, code: rx_byte};

        if (rx_err) begin
            state_d = S_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == PFX_EXT) begin
                        state_d = S_E0;
                    end else if (rx_byte == PFX_BRK) begin
                        state_d = S_F0;
                    end else if (rx_byte == PFX_PAUSE) begin
                        state_d = S_PAUSE;
                        pcnt_d  = '0;
                    end else if (!is_status(rx_byte)) begin
                        dec_push = 1'b1;
                    end
                end
                S_E0: begin
                    if (rx_byte == PFX_BRK) begin
                        state_d = S_E0F0;
                    end else begin
                        state_d = S_IDLE;
                        if (!is_fake_shift(rx_byte)) begin
                            dec_push    = 1'b1;
                            dec_evt.ext = 1'b1;
                        end
                    end
                end
                S_F0: begin
                    state_d     = S_IDLE;
                    dec_push    = 1'b1;
                    dec_evt.brk = 1'b1;
                end
                S_E0F0: begin
                    state_d = S_IDLE;
                    if (!is_fake_shift(rx_byte)) begin
                        dec_push    = 1'b1;
                        dec_evt.ext = 1'b1;
                        dec_evt.brk = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pcnt_q == PAUSE_LAST) begin
                        state_d      = S_IDLE;
                        dec_push     = 1'b1;
                        dec_evt.code = PFX_PAUSE;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if ((state_q != S_IDLE) && (tmr_q == '0)) begin
            state_d = S_IDLE;
        end

        if (rx_valid || (state_q == S_IDLE)) tmr_d = TMR_LOAD;
        else if (tmr_q != '0)                tmr_d = tmr_q - 1'b1;
        else                                 tmr_d = tmr_q;
    end

    assign pop     = evt_valid && evt_ready;
    assign push_ok = !fifo_full || pop;
    assign push    = dec_push && !suppress;

`ifdef PS2_REPEAT_FILTER_EN
    logic [1:0][255:0] held_q;
    logic              dec_make;

    // Pause has no release code, so it is never treated as a held key.
    assign dec_make = !dec_evt.brk && !(!dec_evt.ext && (dec_evt.code == PFX_PAUSE));
    assign suppress = dec_make && held_q[dec_evt.ext][dec_evt.code];

    // Held-key bitmap: set when a make is stored, cleared by any break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else if (dec_push) begin
            if (dec_evt.brk)              held_q[dec_evt.ext][dec_evt.code] <= 1'b0;
            else if (dec_make && push_ok) held_q[dec_evt.ext][dec_evt.code] <= 1'b1;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Sticky overflow: a drop on the same cycle as a clear keeps the flag set.
    assign evt_ovf_d = (push && fifo_full && !pop) || (evt_ovf_q && !ovf_clr);

    // Sequencer state, timer, Pause counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= TMR_LOAD;
            pcnt_q     <= '0;
            seq_busy_q <= 1'b0;
            evt_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pcnt_q     <= pcnt_d;
            seq_busy_q <= (state_d != S_IDLE);
            evt_ovf_q  <= evt_ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (dec_evt),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head      = ps2_evt_t'(fifo_rdata);
    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_empty ? 8'h00 : head.code;
    assign evt_ext   = !fifo_empty && head.ext;
    assign evt_break = !fifo_empty && head.brk;
    assign evt_ovf   = evt_ovf_q;
    assign seq_busy  = seq_busy_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: expected events are queued as bytes
// are driven and compared as the consumer accepts them.
module tb_ps2_scan_sequencer;

    localparam int TO  = 40;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       evt_valid, evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break, evt_ovf, ovf_clr, seq_busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_evt = 0;
    logic [9:0] exp_q[$];
    bit [1:0][255:0] held_m;

    ps2_scan_sequencer #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(DEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr),
        .seq_busy  (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle rx_valid strobe, sampled on the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Expected-event model, including the optional held-key filter.
    task automatic expect_evt(input bit ext, input bit brk, input logic [7:0] code, input bit stored);
`ifdef PS2_REPEAT_FILTER_EN
        if (brk) begin
            held_m[ext][code] = 1'b0;
        end else if (!(code == 8'hE1 && !ext)) begin
            if (held_m[ext][code]) return;
            if (stored) held_m[ext][code] = 1'b1;
        end
`endif
        if (stored) exp_q.push_back({ext, brk, code});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        evt_ready = 1'b1;
        while ((exp_q.size() != 0 || evt_valid) && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_valid"}, 32'(evt_valid), 0);
    endtask

    // Consumer side: compare every accepted head event against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            n_evt++;
            if (exp_q.size() == 0) chk("spurious_evt", 32'(evt_valid), 0);
            else chk("evt", {22'd0, evt_ext, evt_break, evt_code}, 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [7:0] pause_tail [7];
        logic [7:0] status [6];
        logic [7:0] rpt [6];
        pause_tail = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        status     = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        rpt        = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        held_m = '0;

        rst_n = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code",  32'(evt_code), 0);
        chk("rst_ext",   32'(evt_ext), 0);
        chk("rst_brk",   32'(evt_break), 0);
        chk("rst_ovf",   32'(evt_ovf), 0);
        chk("rst_busy",  32'(seq_busy), 0);
        rst_n = 1'b1;
        tick(2);

        // Single make and its latency.
        chk("idle_valid", 32'(evt_valid), 0);
        expect_evt(0, 0, 8'h1C, 1);
        send(8'h1C);
        chk("lat_valid", 32'(evt_valid), 1);
        chk("lat_busy", 32'(seq_busy), 0);
        drain("lat");

        // Extended break E0 F0 74.
        send(8'hE0);
        chk("e0_busy", 32'(seq_busy), 1);
        chk("e0_valid", 32'(evt_valid), 0);
        send(8'hF0);
        chk("e0f0_busy", 32'(seq_busy), 1);
        chk("e0f0_valid", 32'(evt_valid), 0);
        expect_evt(1, 1, 8'h74, 1);
        send(8'h74);
        chk("e0f0_74_valid", 32'(evt_valid), 1);
        chk("e0f0_74_busy", 32'(seq_busy), 0);
        drain("extbrk");

        // Inter-byte timeout discards the prefix.
        send(8'hE0);
        tick(TO - 3);
        chk("to_busy_before", 32'(seq_busy), 1);
        tick(4);
        chk("to_busy_after", 32'(seq_busy), 0);
        chk("to_valid", 32'(evt_valid), 0);
        expect_evt(0, 0, 8'h1B, 1);
        send(8'h1B);
        drain("timeout");

        // Frame error aborts the sequence, alone and together with rx_valid.
        send(8'hE0);
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        chk("err_busy", 32'(seq_busy), 0);
        expect_evt(0, 0, 8'h1D, 1);
        send(8'h1D);
        send(8'hE0);
        rx_err = 1'b1;
        send(8'hF0);
        rx_err = 1'b0;
        chk("errv_busy", 32'(seq_busy), 0);
        expect_evt(0, 0, 8'h2D, 1);
        send(8'h2D);
        drain("err");

        // Fake shifts, extended make, plain break, status bytes.
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h59);
        chk("fake_busy", 32'(seq_busy), 0);
        chk("fake_valid", 32'(evt_valid), 0);
        expect_evt(1, 0, 8'h75, 1);
        send(8'hE0); send(8'h75);
        expect_evt(0, 1, 8'h1C, 1);
        send(8'hF0); send(8'h1C);
        foreach (status[i]) send(status[i]);
        chk("status_busy", 32'(seq_busy), 0);
        drain("misc");

        // Pause: exactly one event after the seventh tail byte.
        send(8'hE1);
        for (int i = 0; i < 6; i++) begin
            send(pause_tail[i]);
            chk("pause_busy", 32'(seq_busy), 1);
            chk("pause_quiet", 32'(evt_valid), 0);
        end
        expect_evt(0, 0, 8'hE1, 1);
        send(pause_tail[6]);
        chk("pause_valid", 32'(evt_valid), 1);
        chk("pause_done", 32'(seq_busy), 0);
        send(8'hAA); send(8'hFA);
        drain("pause");

        // Overflow with the consumer stalled.
        evt_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            expect_evt(0, 0, 8'h30 + 8'(i), 1);
            send(8'h30 + 8'(i));
        end
        chk("full_ovf", 32'(evt_ovf), 0);
        expect_evt(0, 0, 8'h38, 0);
        send(8'h38);
        chk("ovf_set", 32'(evt_ovf), 1);
        tick(2);
        chk("ovf_sticky", 32'(evt_ovf), 1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(evt_ovf), 0);
        ovf_clr = 1'b1;
        expect_evt(0, 0, 8'h39, 0);
        send(8'h39);
        ovf_clr = 1'b0;
        chk("ovf_beats_clr", 32'(evt_ovf), 1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(evt_ovf), 0);
        evt_ready = 1'b1;
        expect_evt(0, 0, 8'h3A, 1);
        send(8'h3A);
        chk("full_push_pop_ovf", 32'(evt_ovf), 0);
        drain("ovf");

        // Asynchronous reset in the middle of a sequence.
        send(8'hE0);
        #3;
        rst_n = 1'b0;
        held_m = '0;
        #1;
        chk("arst_busy", 32'(seq_busy), 0);
        chk("arst_valid", 32'(evt_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        expect_evt(0, 0, 8'h44, 1);
        send(8'h44);
        drain("arst");

        // Typematic repeat handling.
        base = n_evt;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) expect_evt(0, 1, 8'h1C, 1);
            else if (i != 3) expect_evt(0, 0, rpt[i], 1);
            send(rpt[i]);
        end
        drain("rpt");
`ifdef PS2_REPEAT_FILTER_EN
        chk("rpt_count", n_evt - base, 3);
`else
        chk("rpt_count", n_evt - base, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
